// File: rtl/i2c_shift_engine.sv
// I2C frame shifter: one address/write/read frame plus ACK slot per command, MSB-first, open-drain SDA.
// Latency: sda_oe_o valid the cycle after accept; done_o one cycle after the ACK-slot SCL fall. No backpressure, one frame at a time.
module i2c_shift_engine #(
   parameter int DATA_SIZE = 8,
   parameter int ADDR_SIZE = 7,
   parameter int CNT_W     = 4
) (
   input  logic                 i2c_core_clk_i,
   input  logic                 reset_ni,
   input  logic                 start_i,
   input  logic [1:0]           cmd_i,
   input  logic [ADDR_SIZE-1:0] addr_i,
   input  logic                 rw_i,
   input  logic [DATA_SIZE-1:0] data_i,
   input  logic                 ack_en_i,
   input  logic                 abort_i,
   input  logic                 scl_rise_i,
   input  logic                 scl_fall_i,
   input  logic                 i2c_sda_i,
   output logic                 sda_oe_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 ack_err_o,
   output logic [DATA_SIZE-1:0] rx_data_o,
   output logic                 rx_valid_o
);

   // Frames are left-aligned so the bit on the wire is always the register MSB.
   localparam int FW = (DATA_SIZE > ADDR_SIZE + 1) ? DATA_SIZE : ADDR_SIZE + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, ACK, DONE} state_t;

   state_t                state_q, state_d;
   logic [FW-1:0]         frame_q, frame_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  rd_q, rd_d;
   logic                  nack_q, nack_d;
   logic                  sda_oe_q, sda_oe_d;
   logic [DATA_SIZE-1:0]  rx_data_q, rx_data_d;

   always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= IDLE;
         frame_q   <= '0;
         cnt_q     <= '0;
         rd_q      <= 1'b0;
         nack_q    <= 1'b0;
         sda_oe_q  <= 1'b0;
         rx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         frame_q   <= frame_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         nack_q    <= nack_d;
         sda_oe_q  <= sda_oe_d;
         rx_data_q <= rx_data_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      frame_d   = frame_q;
      cnt_d     = cnt_q;
      rd_d      = rd_q;
      nack_d    = nack_q;
      sda_oe_d  = sda_oe_q;
      rx_data_d = rx_data_q;
      if (abort_i) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               sda_oe_d = 1'b0;
               if (start_i && cmd_i != 2'b11) begin
                  state_d = SHIFT;
                  nack_d  = 1'b0;
                  rd_d    = (cmd_i == 2'b10);
                  case (cmd_i)
                     2'b00: begin
                        frame_d = FW'({addr_i, rw_i}) << (FW - ADDR_SIZE - 1);
                        cnt_d   = CNT_W'(ADDR_SIZE);
                     end
                     2'b01: begin
                        frame_d = FW'(data_i) << (FW - DATA_SIZE);
                        cnt_d   = CNT_W'(DATA_SIZE - 1);
                     end
                     default: begin
                        frame_d = '0;
                        cnt_d   = CNT_W'(DATA_SIZE - 1);
                     end
                  endcase
                  sda_oe_d = (cmd_i == 2'b10) ? 1'b0 : ~frame_d[FW-1];
               end
            end
            SHIFT: begin
               // Fall wins over a coincident rise; the rise is dropped.
               if (scl_fall_i) begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - 1'b1;
                     if (!rd_q) frame_d = frame_q << 1;
                     sda_oe_d = rd_q ? 1'b0 : ~frame_d[FW-1];
                  end else begin
                     state_d  = ACK;
                     sda_oe_d = rd_q ? ack_en_i : 1'b0;
                  end
               end else if (scl_rise_i && rd_q) begin
                  frame_d = {frame_q[FW-2:0], i2c_sda_i};
               end
            end
            ACK: begin
               if (scl_fall_i) begin
                  state_d  = DONE;
                  sda_oe_d = 1'b0;
                  if (rd_q) rx_data_d = frame_q[DATA_SIZE-1:0];
               end else if (scl_rise_i && !rd_q) begin
                  nack_d = i2c_sda_i;
               end
            end
            default: begin
               state_d  = IDLE;
               sda_oe_d = 1'b0;
            end
         endcase
      end
   end

   assign sda_oe_o   = sda_oe_q;
   assign busy_o     = (state_q == SHIFT) || (state_q == ACK);
   assign done_o     = (state_q == DONE);
   assign ack_err_o  = (state_q == DONE) && !rd_q && nack_q;
   assign rx_valid_o = (state_q == DONE) && rd_q;
   assign rx_data_o  = rx_data_q;

endmodule

// File: tb/tb_i2c_shift_engine.sv
// Randomised bench for i2c_shift_engine: an 8/7 build and a 16/10 build driven by one SCL strobe generator.
module tb_i2c_shift_engine;

   localparam int DW  = 8;
   localparam int AW  = 7;
   localparam int DW2 = 16;
   localparam int AW2 = 10;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start8, start16, rw, ack_en, abort, rise, fall, sda;
   logic [1:0]  cmd;
   logic [9:0]  addr;
   logic [15:0] data;

   logic        oe8, busy8, done8, err8, rxv8;
   logic [7:0]  rx8;
   logic        oe16, busy16, done16, err16, rxv16;
   logic [15:0] rx16;

   i2c_shift_engine #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .CNT_W(4)) u_dut8 (
      .i2c_core_clk_i(clk), .reset_ni(rst_n), .start_i(start8), .cmd_i(cmd),
      .addr_i(addr[AW-1:0]), .rw_i(rw), .data_i(data[DW-1:0]), .ack_en_i(ack_en),
      .abort_i(abort), .scl_rise_i(rise), .scl_fall_i(fall), .i2c_sda_i(sda),
      .sda_oe_o(oe8), .busy_o(busy8), .done_o(done8), .ack_err_o(err8),
      .rx_data_o(rx8), .rx_valid_o(rxv8));

   i2c_shift_engine #(.DATA_SIZE(DW2), .ADDR_SIZE(AW2), .CNT_W(5)) u_dut16 (
      .i2c_core_clk_i(clk), .reset_ni(rst_n), .start_i(start16), .cmd_i(cmd),
      .addr_i(addr), .rw_i(rw), .data_i(data), .ack_en_i(ack_en),
      .abort_i(abort), .scl_rise_i(rise), .scl_fall_i(fall), .i2c_sda_i(sda),
      .sda_oe_o(oe16), .busy_o(busy16), .done_o(done16), .ack_err_o(err16),
      .rx_data_o(rx16), .rx_valid_o(rxv16));

   int          sel;
   logic        oe_s, busy_s, done_s, err_s, rxv_s;
   logic [15:0] rx_s;
   assign oe_s   = (sel != 0) ? oe16   : oe8;
   assign busy_s = (sel != 0) ? busy16 : busy8;
   assign done_s = (sel != 0) ? done16 : done8;
   assign err_s  = (sel != 0) ? err16  : err8;
   assign rxv_s  = (sel != 0) ? rxv16  : rxv8;
   assign rx_s   = (sel != 0) ? rx16   : {8'h00, rx8};

   int done_cnt [2];
   initial begin
      done_cnt[0] = 0;
      done_cnt[1] = 0;
   end
   always @(negedge clk) begin
      if (done8)  done_cnt[0]++;
      if (done16) done_cnt[1]++;
   end

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_rx [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input logic v);
      if (sel != 0) start16 = v;
      else          start8  = v;
   endtask

   // One complete frame. For an address frame val is the address and rwb the R/W bit.
   // flag is the slave ACK-slot level for transmit frames, or ack_en for read frames.
   task automatic run_frame(input int s, input logic [1:0] c, input logic [15:0] val,
                            input logic rwb, input logic flag, input logic glitch_en);
      int          n, aw, dw, d0;
      logic [31:0] fv;
      logic        rd;
      sel = s;
      aw  = (s != 0) ? AW2 : AW;
      dw  = (s != 0) ? DW2 : DW;
      rd  = (c == 2'b10);
      n   = (c == 2'b00) ? aw + 1 : dw;
      if (c == 2'b00) fv = ((32'(val) & ((32'd1 << aw) - 1)) << 1) | 32'(rwb);
      else            fv = 32'(val);
      d0     = done_cnt[s];
      cmd    = c;
      addr   = val[9:0];
      rw     = rwb;
      data   = rd ? 16'($urandom) : val;
      ack_en = rd ? flag : 1'($urandom);
      set_start(1'b1);
      tick();
      set_start(1'b0);
      chk("busy_after_start", busy_s, 1);
      for (int i = n - 1; i >= 0; i--) begin
         chk("bit_oe", oe_s, rd ? 0 : {31'd0, ~fv[i]});
         sda = rd ? val[i] : ~oe_s;
         if ($urandom_range(0, 3) == 0) begin
            cmd  = 2'($urandom);
            data = 16'($urandom);
            set_start(1'b1);
         end
         tick();
         set_start(1'b0);
         rise = 1'b1;
         tick();
         rise = 1'b0;
         fall = 1'b1;
         if (glitch_en && $urandom_range(0, 1) == 1) begin
            rise = 1'b1;
            sda  = ~sda;
         end
         tick();
         fall = 1'b0;
         rise = 1'b0;
         tick();
      end
      chk("ack_oe", oe_s, rd ? {31'd0, flag} : 0);
      chk("no_early_done", done_cnt[s] - d0, 0);
      chk("busy_in_ack", busy_s, 1);
      sda  = rd ? ~flag : flag;
      tick();
      rise = 1'b1;
      tick();
      rise = 1'b0;
      fall = 1'b1;
      tick();
      fall = 1'b0;
      if (rd) exp_rx[s] = (s != 0) ? val : {8'h00, val[7:0]};
      chk("done_pulse", done_s, 1);
      chk("ack_err", err_s, rd ? 0 : {31'd0, flag});
      chk("rx_valid", rxv_s, {31'd0, rd});
      chk("oe_released", oe_s, 0);
      chk("busy_in_done", busy_s, 0);
      chk("rx_data", rx_s, exp_rx[s]);
      tick();
      chk("done_count", done_cnt[s] - d0, 1);
      chk("done_low", done_s, 0);
      chk("rx_valid_low", rxv_s, 0);
      chk("rx_data_held", rx_s, exp_rx[s]);
      sda = 1'b1;
   endtask

   initial begin
      int d0;
      rst_n = 1'b0; start8 = 1'b0; start16 = 1'b0; cmd = 2'b00; addr = '0; rw = 1'b0;
      data = '0; ack_en = 1'b0; abort = 1'b0; rise = 1'b0; fall = 1'b0; sda = 1'b1; sel = 0;
      exp_rx[0] = '0;
      exp_rx[1] = '0;
      repeat (3) tick();
      chk("rst_oe", oe8, 0);
      chk("rst_busy", busy8, 0);
      chk("rst_done", done8, 0);
      chk("rst_err", err8, 0);
      chk("rst_rxv", rxv8, 0);
      chk("rst_rx", rx8, 0);
      chk("rst_rx16", rx16, 0);
      rst_n = 1'b1;
      tick();

      run_frame(0, 2'b01, 16'h00A5, 1'b0, 1'b0, 1'b0);
      run_frame(0, 2'b00, 16'h0050, 1'b1, 1'b1, 1'b0);
      run_frame(0, 2'b10, 16'h003C, 1'b0, 1'b1, 1'b0);
      run_frame(0, 2'b10, 16'h003C, 1'b0, 1'b0, 1'b1);

      // Reserved command in IDLE.
      sel = 0; cmd = 2'b11; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      chk("cmd11_busy", busy8, 0);
      chk("cmd11_oe", oe8, 0);
      tick();
      chk("cmd11_busy2", busy8, 0);

      // Abort after the third bit of a write of 0x00 (SDA held low).
      d0 = done_cnt[0]; cmd = 2'b01; data = 16'h0000; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      for (int b = 0; b < 3; b++) begin
         tick(); rise = 1'b1; tick(); rise = 1'b0; fall = 1'b1; tick(); fall = 1'b0; tick();
      end
      chk("pre_abort_oe", oe8, 1);
      chk("pre_abort_busy", busy8, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_oe", oe8, 0);
      chk("abort_busy", busy8, 0);
      chk("abort_rx", rx8, exp_rx[0]);
      repeat (6) begin
         fall = 1'b1; tick(); fall = 1'b0; tick();
      end
      chk("abort_no_done", done_cnt[0] - d0, 0);
      chk("abort_idle", busy8, 0);

      for (int k = 0; k < 24; k++)
         run_frame(0, 2'($urandom_range(0, 2)), 16'($urandom), 1'($urandom),
                   1'($urandom), 1'b1);

      run_frame(1, 2'b01, 16'hBEEF, 1'b0, 1'b0, 1'b0);
      run_frame(1, 2'b00, 16'h0 | 16'($urandom_range(0, 1023)), 1'b0, 1'b0, 1'b0);
      run_frame(1, 2'b10, 16'($urandom), 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 6; k++)
         run_frame(1, 2'($urandom_range(0, 2)), 16'($urandom), 1'($urandom),
                   1'($urandom), 1'b1);

      // Make sure the 8-bit build holds a nonzero byte, then reset mid-frame.
      run_frame(0, 2'b10, 16'h005A, 1'b0, 1'b1, 1'b0);
      sel = 0; cmd = 2'b01; data = 16'h0000; start8 = 1'b1;
      tick();
      start8 = 1'b0;
      tick(); rise = 1'b1; tick(); rise = 1'b0; fall = 1'b1; tick(); fall = 1'b0;
      chk("pre_reset_oe", oe8, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_oe", oe8, 0);
      chk("async_rst_busy", busy8, 0);
      chk("async_rst_rx", rx8, 0);
      chk("async_rst_rx16", rx16, 0);
      exp_rx[0] = '0;
      exp_rx[1] = '0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      run_frame(0, 2'b01, 16'($urandom), 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_shift_engine.md
Name: i2c_shift_engine

Overview:
- Parametrised successor of the I2C core-side data path. It serialises one frame per command onto SDA and deserialises one frame from SDA: an address frame, a write-data frame or a read-data frame, each followed by an ACK slot.
- Frames are MSB-first with a real bit counter, an internal frame register and ACK handling. SDA is driven open-drain.
- Sits between the master control FSM, the SCL generator that supplies phase strobes, and the TX/RX FIFOs.

Parameters:
- DATA_SIZE, 8, width of data frames in bits (>=2).
- ADDR_SIZE, 7, slave address width; an address frame is ADDR_SIZE+1 bits ({addr, rw}).
- CNT_W, 4, bit-counter width; must satisfy 2^CNT_W > max(DATA_SIZE, ADDR_SIZE+1).

Ports:
- i2c_core_clk_i  in  1  core clock; the only clock.
- reset_ni  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle command strobe; accepted only in IDLE.
- cmd_i  in  2  00 = address frame, 01 = write frame, 10 = read frame, 11 = reserved (ignored).
- addr_i  in  ADDR_SIZE  slave address, sampled on accept.
- rw_i  in  1  R/W bit appended to the address frame (1 = read).
- data_i  in  DATA_SIZE  TX byte from FIFO, sampled on accept.
- ack_en_i  in  1  read frame only: 1 = master ACKs, 0 = master NACKs (last byte).
- abort_i  in  1  synchronous abort.
- scl_rise_i  in  1  one-cycle strobe: SCL rising edge (sample point).
- scl_fall_i  in  1  one-cycle strobe: SCL falling edge (change point).
- i2c_sda_i  in  1  synchronised SDA line level.
- sda_oe_o  out  1  1 = pull SDA low, 0 = release.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse at frame end.
- ack_err_o  out  1  valid with done_o: slave NACKed an address or write frame.
- rx_data_o  out  DATA_SIZE  received byte; held until the next read completes.
- rx_valid_o  out  1  one-cycle pulse with done_o for a completed read frame.

Behaviour:
- Reset (async, reset_ni=0): state IDLE, sda_oe_o=0, busy_o=0, done_o=0, ack_err_o=0, rx_data_o=0, rx_valid_o=0, frame register and counter cleared. Reset mid-frame releases SDA immediately.
- States: IDLE, SHIFT, ACK, DONE.
- IDLE + start_i with a valid cmd: load the frame register and the counter, then go to SHIFT; busy_o=1 from the next cycle.
  - Address frame: register {addr_i, rw_i}, counter = ADDR_SIZE.
  - Write frame: register data_i, counter = DATA_SIZE-1.
  - Read frame: counter = DATA_SIZE-1.
- start_i while busy, or cmd 11, is ignored with no state change.
- SHIFT, transmit (address/write): sda_oe_o = ~frame_msb, registered, valid from the cycle after accept.
  - scl_fall_i with counter>0: shift left and decrement.
  - scl_fall_i with counter==0: go to ACK with sda_oe_o=0.
- SHIFT, read: sda_oe_o=0.
  - scl_rise_i: shift i2c_sda_i into the LSB.
  - scl_fall_i: same counter rule as transmit. Entering ACK sets sda_oe_o = ack_en_i.
- ACK:
  - Transmit: scl_rise_i samples i2c_sda_i into a NACK flag (1 = NACK).
  - Read: master drives or releases per the value latched on entry.
  - scl_fall_i: go to DONE and release SDA.
- DONE, one cycle: done_o=1, ack_err_o = NACK flag (transmit only, 0 for read), rx_valid_o=1 and rx_data_o updated for reads; busy_o=0 from that cycle. Next state IDLE, so a new start_i is accepted in the cycle after DONE.
- scl_rise_i and scl_fall_i asserted together: illegal. Fall takes priority and rise is ignored.
- abort_i in any state: next cycle IDLE, sda_oe_o=0, busy_o=0, no done_o or rx_valid_o; rx_data_o unchanged.
- Frame length: exactly N data-bit SCL periods plus 1 ACK period (N = DATA_SIZE or ADDR_SIZE+1). The counter never wraps.

Test Plan:
- Write cmd, data_i=0xA5, slave ACKs (SDA=0 at ACK rise) -> sda_oe_o per bit 0,1,0,1,1,0,1,0, then 0 in ACK; done_o one pulse after the 9th scl_fall_i; ack_err_o=0.
- Address cmd, addr_i=0x50, rw_i=1 -> serial frame 0xA1 (bits 1,0,1,0,0,0,0,1); slave leaves SDA high at ACK -> done_o with ack_err_o=1.
- Read cmd, SDA pattern 0x3C sampled on rises, ack_en_i=1 -> sda_oe_o=1 during the ACK slot; rx_data_o=0x3C with rx_valid_o pulse. Repeat with ack_en_i=0 -> SDA released in ACK.
- start_i pulsed mid-frame and cmd 11 in IDLE -> ignored; frame bits and counter unaffected.
- abort_i after the 3rd bit -> IDLE next cycle, sda_oe_o=0, no done_o; reset_ni low mid-frame -> all outputs reset asynchronously.
- DATA_SIZE=16, ADDR_SIZE=10 build -> 16+1 and 11+1 SCL periods per frame; 0xBEEF transmitted MSB-first.
